// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side pointer/flag controller for the async FIFO (optional registered level via FIFO_WR_LEVEL_EN)
module fifo_write_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_GAP = 2
) (
    input  logic                  write_clk,
    input  logic                  write_rst,
    input  logic                  write_req,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    input  logic [ADDR_WIDTH:0]   read_ptr_gray,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH:0]   write_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   write_level
);
    localparam int PW        = ADDR_WIDTH + 1;
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic          accept;
    logic [PW-1:0] wptr_bin, wptr_next, wgray_next;
    logic [PW-1:0] rsync1, rsync2, rptr_bin, full_cmp, level;
    logic          almost_full_next;

    assign accept     = write_req & ~full & ~write_rst;
    assign write_en   = accept;
    assign write_addr = wptr_bin[ADDR_WIDTH-1:0];
    assign write_data = write_data_in;

    assign wptr_next  = wptr_bin + PW'(accept);
    assign wgray_next = wptr_next ^ (wptr_next >> 1);

    // The writer has lapped the reader exactly when its Gray pointer equals
    // the synced read pointer with the top two Gray bits inverted.
    assign full_cmp = {~rsync2[PW-1:PW-2], rsync2[PW-3:0]};

    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign rptr_bin[i] = ^rsync2[PW-1:i];
    end

    assign level            = wptr_next - rptr_bin;
    assign almost_full_next = ({1'b0, level} + (PW+1)'(ALMOST_FULL_GAP)) >= (PW+1)'(RAM_DEPTH);

    // Pointer advance, read-pointer synchroniser and registered status flags
    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            wptr_bin       <= '0;
            write_ptr_gray <= '0;
            rsync1         <= '0;
            rsync2         <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            wptr_bin       <= wptr_next;
            write_ptr_gray <= wgray_next;
            rsync1         <= read_ptr_gray;
            rsync2         <= rsync1;
            full           <= (wgray_next == full_cmp);
            almost_full    <= almost_full_next;
            overflow       <= write_req & full;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    // Registered occupancy as seen from the write side
    always_ff @(posedge write_clk) begin
        if (write_rst) write_level <= '0;
        else           write_level <= level;
    end
`else
    assign write_level = '0;
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: randomized and directed checks of fifo_write_ctrl against an occupancy-count model
module tb_fifo_write_ctrl;
    localparam int DW = 8, AW = 4, GAP = 2, DEPTH = 16, PM = 32;

    logic          write_clk = 1'b0, write_rst = 1'b0, write_req = 1'b0;
    logic [DW-1:0] write_data_in = '0;
    logic [AW:0]   read_ptr_gray = '0;
    logic          write_en, full, almost_full, overflow;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW:0]   write_ptr_gray, write_level;

    fifo_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_GAP(GAP)) dut (
        .write_clk(write_clk), .write_rst(write_rst), .write_req(write_req),
        .write_data_in(write_data_in), .read_ptr_gray(read_ptr_gray),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .write_ptr_gray(write_ptr_gray), .full(full), .almost_full(almost_full),
        .overflow(overflow), .write_level(write_level)
    );

    always #5 write_clk = ~write_clk;

    int tests = 0, fails = 0;
    int wcnt = 0, rd = 0, lvl_m = 0;
    bit full_m = 0, af_m = 0, ovf_m = 0;
    int rhist[$];

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = (AW+1)'(b % PM);
        return v ^ (v >> 1);
    endfunction

    // One clock: drive inputs, check combinational RAM drive, advance model, check registered outputs
    task automatic step(input bit req, input bit rst);
        int rs2, wn, exp_lvl;
        bit acc;
        logic [AW:0] pg;
        write_req = req;
        write_rst = rst;
        write_data_in = DW'($urandom);
        read_ptr_gray = gray(rd);
        @(negedge write_clk);
        acc = req && !full_m && !rst;
        tests++; if (write_en !== acc) begin fails++; $display("FAIL write_en: got %0b want %0b", write_en, acc); end
        tests++; if (write_addr !== AW'(wcnt % DEPTH)) begin fails++; $display("FAIL write_addr: got %0d want %0d", write_addr, wcnt % DEPTH); end
        tests++; if (write_data !== write_data_in) begin fails++; $display("FAIL write_data: got %0h want %0h", write_data, write_data_in); end
        pg = write_ptr_gray;
        rs2 = rhist.size() >= 2 ? rhist[rhist.size()-2] : 0;
        wn = acc ? wcnt + 1 : wcnt;
        @(posedge write_clk);
        #1;
        if (rst) begin
            wcnt = 0; rd = 0; full_m = 0; af_m = 0; ovf_m = 0; lvl_m = 0;
            rhist = '{0};
        end else begin
            ovf_m = req && full_m;
            wcnt = wn;
            lvl_m = ((wn - rs2) % PM + PM) % PM;
            full_m = (lvl_m == DEPTH);
            af_m = (DEPTH - lvl_m) <= GAP;
            rhist.push_back(rd);
            tests++; if ($countones(pg ^ write_ptr_gray) > 1) begin fails++; $display("FAIL gray_step: %0h -> %0h", pg, write_ptr_gray); end
        end
`ifdef FIFO_WR_LEVEL_EN
        exp_lvl = lvl_m;
`else
        exp_lvl = 0;
`endif
        tests++; if (write_ptr_gray !== gray(wcnt)) begin fails++; $display("FAIL write_ptr_gray: got %0h want %0h", write_ptr_gray, gray(wcnt)); end
        tests++; if (full !== full_m) begin fails++; $display("FAIL full: got %0b want %0b", full, full_m); end
        tests++; if (almost_full !== af_m) begin fails++; $display("FAIL almost_full: got %0b want %0b", almost_full, af_m); end
        tests++; if (overflow !== ovf_m) begin fails++; $display("FAIL overflow: got %0b want %0b", overflow, ovf_m); end
        tests++; if (write_level !== (AW+1)'(exp_lvl)) begin fails++; $display("FAIL write_level: got %0d want %0d", write_level, exp_lvl); end
    endtask

    task automatic test_reset();
        step(1, 1);
        tests++; if ({write_ptr_gray, full, almost_full, overflow, write_level} !== '0) begin fails++; $display("FAIL reset_state: got %0h want 0", {write_ptr_gray, full, almost_full, overflow, write_level}); end
    endtask

    task automatic test_fill();
        step(0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0);
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %0b want 1", full); end
        tests++; if (write_ptr_gray !== 5'h18) begin fails++; $display("FAIL fill_gray: got %0h want 18", write_ptr_gray); end
    endtask

    task automatic test_write_while_full();
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %0b want 1", overflow); end
            tests++; if (write_ptr_gray !== 5'h18) begin fails++; $display("FAIL ovf_gray: got %0h want 18", write_ptr_gray); end
        end
    endtask

    task automatic test_drain();
        rd = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            tests++; if (full !== (i < 2)) begin fails++; $display("FAIL drain_full_edge%0d: got %0b want %0b", i + 1, full, i < 2); end
        end
        step(1, 0);
        tests++; if (write_ptr_gray !== 5'h19) begin fails++; $display("FAIL drain_gray: got %0h want 19", write_ptr_gray); end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        step(0, 1);
        for (int i = 0; i < 40; i++) begin
            rd = wcnt > 4 ? wcnt - 4 : 0;
            step(1, 0);
            if (wcnt % DEPTH == 0) wraps++;
            tests++; if (full !== 1'b0) begin fails++; $display("FAIL wrap_full: got %0b want 0", full); end
        end
        tests++; if (wraps != 2 || write_ptr_gray !== 5'h0c) begin fails++; $display("FAIL wrap_end: wraps %0d gray %0h want 2/0c", wraps, write_ptr_gray); end
    endtask

    task automatic test_almost_full();
        step(0, 1);
        for (int i = 0; i < 13; i++) step(1, 0);
        tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL af_13: got %0b want 0", almost_full); end
        step(1, 0);
        tests++; if (almost_full !== 1'b1) begin fails++; $display("FAIL af_14: got %0b want 1", almost_full); end
`ifdef FIFO_WR_LEVEL_EN
        tests++; if (write_level !== 5'd14) begin fails++; $display("FAIL level_14: got %0d want 14", write_level); end
`endif
    endtask

    task automatic test_reset_midfill();
        step(0, 1);
        for (int i = 0; i < 7; i++) step(1, 0);
        step(1, 1);
        tests++; if ({write_ptr_gray, full, almost_full} !== '0) begin fails++; $display("FAIL midfill_reset: got %0h want 0", {write_ptr_gray, full, almost_full}); end
        step(1, 0);
        tests++; if (write_ptr_gray !== 5'h01) begin fails++; $display("FAIL midfill_next: got %0h want 01", write_ptr_gray); end
    endtask

    task automatic test_random();
        step(0, 1);
        for (int i = 0; i < 600; i++) begin
            if (rd < wcnt && $urandom_range(0, 99) < 45) rd++;
            step($urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_while_full();
        test_drain();
        test_wrap();
        test_almost_full();
        test_reset_midfill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
